// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor duty ramp slice.
// Signed command range, ramp states and saturation helpers.
package mtr_pkg;

  localparam int PWM_W = 11;

  localparam logic [PWM_W-1:0] DUTY_MAX = 11'h7FF;

  typedef logic signed [11:0] mtr_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD,
    DWELL
  } ramp_state_t;

  // Fold the single asymmetric code so |target| fits the duty width.
  function automatic mtr_cmd_t sat_cmd(input mtr_cmd_t c);
    mtr_cmd_t lim;
    lim = mtr_cmd_t'({1'b0, DUTY_MAX});
    if (c == mtr_cmd_t'(12'h800)) begin
      return -lim;
    end
    return c;
  endfunction

  // Magnitude of a setpoint, kept 12 bits wide for step math.
  function automatic logic [11:0] mag(input mtr_cmd_t c);
    logic [11:0] m;
    m = c[11] ? 12'(-c) : 12'(c);
    return m;
  endfunction

  // Target lies on the other side of zero from the drive direction.
  function automatic logic opp_side(
    input mtr_cmd_t tgt,
    input logic     fwd
  );
    return (tgt != '0) && (tgt[11] == fwd);
  endfunction

  // State implied by a setpoint/target/direction triple.
  function automatic ramp_state_t classify(
    input mtr_cmd_t cur,
    input mtr_cmd_t tgt,
    input logic     fwd
  );
    ramp_state_t s;
    if ((cur == '0) && (tgt == '0)) begin
      s = IDLE;
    end else if (cur == tgt) begin
      s = HOLD;
    end else if ((cur == '0) && opp_side(tgt, fwd)) begin
      s = DWELL;
    end else begin
      s = RAMP;
    end
    return s;
  endfunction

endpackage

// File: rtl/mtr_duty_ramp_tick.sv
// Free-running period counter shared by period-synchronous stages.
// Tick marks the last clock of each 2**PER_W clock period.
module pwm_period_tick #(
  parameter int PER_W = 11
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  logic [PER_W-1:0] r_cnt;

  // Count every clock, wrapping naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PER_W'(1);
    end
  end

  assign o_tick = &r_cnt;

endmodule

// File: rtl/mtr_duty_ramp.sv
// Slews a signed drive command toward target once per PWM period.
// Emits magnitude duty, direction and enable for the H-bridge stage.
module mtr_duty_ramp
  import mtr_pkg::*;
#(
  parameter int STEP  = 16,
  parameter int PER_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      cmd,
  input  logic             cmd_vld,
  input  logic             estop,
  output logic [PWM_W-1:0] duty,
  output logic             fwd,
  output logic             pwm_en,
  output logic             at_target
);

  localparam logic [11:0] STEP_M = 12'(STEP);

  logic            w_tick;
  logic [11:0]     w_mag_c;
  logic [11:0]     w_goal;
  logic [11:0]     w_mag_n;
  logic            w_fwd_n;
  mtr_cmd_t        w_cur_n;
  mtr_cmd_t        w_tgt_n;
  ramp_state_t     w_state_n;

  mtr_cmd_t        r_cur;
  mtr_cmd_t        r_tgt;
  logic            r_fwd;
  logic [PWM_W-1:0] r_duty;
  logic            r_pwm_en;
  logic            r_at_target;
  ramp_state_t     r_state;

  pwm_period_tick #(
    .PER_W (PER_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_mag_c = mag(r_cur);

  // Crossing zero means heading for zero first; else chase |target|.
  assign w_goal = opp_side(r_tgt, r_fwd) ? 12'd0 : mag(r_tgt);

  // Next setpoint, direction, target and state; estop wins outright.
  always_comb begin
    w_mag_n = w_mag_c;
    w_fwd_n = r_fwd;
    w_tgt_n = r_tgt;
    if (estop) begin
      w_mag_n = '0;
      w_tgt_n = '0;
    end else begin
      if (cmd_vld) begin
        w_tgt_n = sat_cmd(mtr_cmd_t'(cmd));
      end
      if (w_tick) begin
        unique case (r_state)
          DWELL: begin
            w_fwd_n = ~r_fwd;
          end
          RAMP: begin
            if (w_goal > w_mag_c) begin
              if ((w_goal - w_mag_c) <= STEP_M) begin
                w_mag_n = w_goal;
              end else begin
                w_mag_n = w_mag_c + STEP_M;
              end
            end else if (w_goal < w_mag_c) begin
              if ((w_mag_c - w_goal) <= STEP_M) begin
                w_mag_n = w_goal;
              end else begin
                w_mag_n = w_mag_c - STEP_M;
              end
            end
          end
          default: begin
            w_mag_n = w_mag_c;
          end
        endcase
      end
    end
    if (w_fwd_n) begin
      w_cur_n = mtr_cmd_t'(w_mag_n);
    end else begin
      w_cur_n = mtr_cmd_t'(-w_mag_n);
    end
    w_state_n = classify(w_cur_n, w_tgt_n, w_fwd_n);
  end

  // State register of the ramp FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Setpoint, target and all outputs move together on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur       <= '0;
      r_tgt       <= '0;
      r_fwd       <= 1'b1;
      r_duty      <= '0;
      r_pwm_en    <= 1'b0;
      r_at_target <= 1'b1;
    end else begin
      r_cur       <= w_cur_n;
      r_tgt       <= w_tgt_n;
      r_fwd       <= w_fwd_n;
      r_duty      <= w_mag_n[PWM_W-1:0];
      r_pwm_en    <= (w_mag_n != '0);
      r_at_target <= (w_state_n == IDLE) || (w_state_n == HOLD);
    end
  end

  assign duty      = r_duty;
  assign fwd       = r_fwd;
  assign pwm_en    = r_pwm_en;
  assign at_target = r_at_target;

endmodule

// File: doc/mtr_duty_ramp.md
Name: mtr_duty_ramp

Overview:
- Upstream stage of the 11-bit PWM generator.
- Accepts a signed 12-bit drive command and slews it toward target by a fixed step once per PWM period.
- Outputs an 11-bit unsigned magnitude duty, a direction bit and an enable for the PWM/H-bridge stage.
- Duty changes only on PWM period boundaries, so no mid-period glitches. Direction reversal passes through a zero-duty dwell period.

Parameters:
- STEP, 16: magnitude increment/decrement per period. Legal range 1..2047.
- PER_W, 11: period counter width. The period is 2**PER_W clocks and must match the downstream PWM counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- cmd  in  12  signed target duty, two's complement
- cmd_vld  in  1  single-cycle qualifier; cmd is latched as target on any cycle
- estop  in  1  synchronous emergency stop, level-sensitive
- duty  out  11  registered magnitude of current setpoint
- fwd  out  1  registered direction: 1 = forward (cur ≥ 0 side), 0 = reverse
- pwm_en  out  1  registered; 1 iff duty != 0
- at_target  out  1  registered; 1 iff current setpoint == target

Behaviour:
- Reset values: duty=0, fwd=1, pwm_en=0, at_target=1, internal target=0, current=0, period counter=0, state=IDLE.
- Period counter: free-running PER_W bits, wraps at 2**PER_W-1.
  - tick = (cnt == all-ones).
  - Released from reset on the same edge as the PWM counter, so outputs registered on tick take effect as the PWM counter wraps to 0.
- Target latch: on cmd_vld & !estop, target <= sat(cmd).
  - sat maps -2048 to -2047; all other values pass unchanged.
  - Target range is -2047..2047.
- Current setpoint: internal signed 12-bit cur; duty=|cur|, fwd=sign side. Updated only on tick.
- States:
  - IDLE (cur==0, target==0).
  - RAMP (moving toward a same-sign target).
  - HOLD (cur==target).
  - DWELL (cur==0, target of opposite sign to fwd).
- Tick rules, same sign or cur==0 with matching fwd:
  - If |target| > |cur|: cur steps away from 0 by STEP, clamped at target.
  - If |target| < |cur|: cur steps toward 0 by STEP, clamped at target.
- Tick rules, target sign opposite to fwd:
  - cur steps toward 0 by STEP, clamped at 0.
  - On the first tick with cur==0 (DWELL): fwd toggles and duty stays 0.
  - Subsequent ticks ramp in the new direction.
- Target 0 from any state: ramp to 0, then IDLE. fwd holds its last value.
- at_target and pwm_en are recomputed on the same edge as duty.
- Simultaneous cmd_vld and tick: the step uses the old target; the new target applies from the next tick.
- estop high at any clock edge:
  - Next edge: cur=0, target=0, duty=0, pwm_en=0, at_target=1, state=IDLE. fwd unchanged.
  - cmd_vld is ignored while estop is high.
  - estop does not wait for tick.
- After estop deasserts: outputs remain 0 until a new cmd_vld.
- Reset mid-ramp: asynchronous return to reset values. The period counter restarts at 0.
- Arithmetic: all magnitude math in 12 bits. Clamp compares occur before register load, so no overflow is possible (2047+STEP fits after clamp).

Decomposition:
- Shared package mtr_pkg:
  - PWM_W=11.
  - typedef logic signed [11:0] mtr_cmd_t.
  - enum ramp_state_t {IDLE, RAMP, HOLD, DWELL}.
  - DUTY_MAX=11'h7FF.
- One natural sub-module: pwm_period_tick, a PER_W-bit free-running counter emitting tick. It is reusable by other period-synchronous stages.

Test Plan:
1. Release reset, hold cmd_vld=0 for 3 periods -> duty=0, fwd=1, pwm_en=0, at_target=1 throughout.
2. cmd=+100 with cmd_vld at cycle 10 -> duty 16,32,48,64,80,96,100 on ticks 1-7; at_target=1 only after tick 7; pwm_en=1 from tick 1.
3. Settled at +40, cmd=-40 -> duty 24,8,0, then 0 with fwd=0 (DWELL), then 16,32,40; at_target=1 after the last step.
4. cmd=-2048 (12'h800) -> target -2047; fwd=0 after the first dwell tick; duty reaches 2047 (11'h7FF) after 128 steps.
   - Final step clamps from 2032 to 2047 with no wrap.
5. Ramping with duty=64, assert estop for 5 cycles and pulse cmd_vld=+500 during it -> duty=0 and pwm_en=0 one clock after estop.
   - After release, duty stays 0 through 3 ticks (command ignored).
6. cmd_vld=+200 on the same clock as tick while the old target is +32 and cur=+16 -> duty=32 at that tick, then 48 at the next.
   - Separately, asserting rst_n low mid-ramp -> all outputs at reset values immediately.
